fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage directly upstream of the datapath/controller pair.
//   Owns the PC, issues pipelined requests to instruction memory and buffers in-order responses in a small FIFO.
//   Presents {inst, inst_pc} to decode with a valid/ready handshake.
//   Flushes and restarts on a redirect (branch/jump) from the execute stage.
// PARAMETERS
//   XLEN        32            data/address width
//   FIFO_DEPTH  4             instruction buffer entries; also max outstanding requests (power of 2, >=2)
//   RESET_PC    32'h0000_0000 first fetch address after reset
// PORTS
//   clk             in   1     rising-edge clock
//   reset           in   1     asynchronous, active-low reset
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     memory accepts request
//   imem_req_addr   out  XLEN  word-aligned fetch address
//   imem_rsp_valid  in   1     response valid (in order; no backpressure)
//   imem_rsp_data   in   32    fetched instruction
//   redirect_valid  in   1     flush and restart fetch
//   redirect_pc     in   XLEN  restart address ([1:0] ignored, forced 0)
//   inst_valid      out  1     FIFO head valid
//   inst_ready      in   1     decode consumes head
//   inst            out  32    head instruction
//   inst_pc         out  XLEN  head PC
// BEHAVIOUR
//   Reset (reset==0, async):
//     - pc_q=RESET_PC, outstanding O=0, drop D=0, FIFO empty.
//     - inst_valid=0, imem_req_valid=0; inst and inst_pc read 0.
//   Issue: imem_req_valid = !redirect_valid && (O + count < FIFO_DEPTH).
//     - Request handshake (valid&&ready): pc_q += 4, O++.
//     - pc_q wraps 32'hFFFF_FFFC -> 0.
//     - Response without a redirect: O--, with D as described under Response.
//   imem_req_addr = pc_q.
//     - Held stable while valid&&!ready.
//     - May drop without a handshake only in a redirect cycle; memory treats that as abort.
//   Response: if D>0, discard and D--.
//     - Otherwise push {imem_rsp_data, pc of that request}; O-- either way.
//     - The credit rule guarantees the FIFO never overflows; no rsp backpressure is needed.
//     - Each FIFO entry's PC is the pc_q value at request-issue time.
//     - The PC is carried in a small in-flight PC queue of depth FIFO_DEPTH.
//   Redirect (one cycle):
//     - FIFO cleared; any pop that cycle is ignored.
//     - pc_q <= {redirect_pc[XLEN-1:2],2'b00}.
//     - D <= O - imem_rsp_valid; O <= O - imem_rsp_valid.
//     - A response arriving in that cycle is discarded.
//     - Back-to-back redirects are handled; the last redirect wins.
//   Output: inst_valid = FIFO not empty; pop on inst_valid&&inst_ready.
//     - Push and pop may occur in the same cycle; count is unchanged.
//   Latency: rsp at cycle N -> inst_valid at N+1 (registered FIFO, no bypass).
//   Reset mid-operation: all state cleared; later stale responses are a system error, not handled.
// CONFIGURATION
//   FETCH_PERF_EN defined:
//     - adds out ports perf_fetched[31:0] (pops) and perf_stall[31:0] (cycles with inst_ready && !inst_valid);
//     - both cleared on reset, wrap at 2^32.
//   Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//   Shared package riscv_pkg gains:
//     - typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] inst;};
//     - constant NOP_INST = 32'h0000_0013.
//   Sub-module fetch_fifo:
//     - generic sync FIFO of fetch_entry_t, depth FIFO_DEPTH;
//     - push/pop/flush inputs, count output;
//     - also instantiated as the in-flight PC queue.
// TESTING
//   1. Streaming: release reset, ready=1, 1-cycle mem latency, inst_ready=1
//      -> inst_pc 0,4,8,12... on consecutive cycles after 2-cycle startup.
//   2. Backpressure: inst_ready=0 for 10 cycles
//      -> exactly 4 entries buffered, imem_req_valid=0.
//      Then release -> PCs continue with no gap or duplicate.
//   3. Redirect with 3 outstanding: redirect_pc=0x100
//      -> next 3 responses dropped, first inst_pc=0x100, FIFO empty the cycle after the redirect.
//   4. Redirect coincides with a response and an inst_ready pop
//      -> response dropped, pop ignored, D=O_old-1.
//   5. Wrap: RESET_PC=32'hFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   6. Async reset asserted mid-burst (between clock edges)
//      -> outputs 0 immediately; restart fetch at RESET_PC.
//   With FETCH_PERF_EN: scenario 2 -> perf_stall unchanged, perf_fetched counts every pop.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: the fetch buffer entry and the canonical NOP encoding.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush; DEPTH must be a power of two.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wr_data_i,
  output fetch_entry_t rd_data_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; count_q gates whether any entry is meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response buffer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
`endif
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   buf_cnt;
  fetch_entry_t    pcq_wr, pcq_head;
  fetch_entry_t    buf_wr, buf_head;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_keep;
  logic            unused_bits;

  // Outstanding requests plus buffered entries never exceed the buffer depth,
  // so every response has a guaranteed slot.
  assign credit_ok      = ({1'b0, out_cnt} + {1'b0, buf_cnt}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_q == '0);

  // NOTE: defaults first so no path through the block leaves a latch behind.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = out_cnt - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // The in-flight queue is never flushed: its occupancy is the outstanding
  // count, and each response (kept or dropped) retires its head.
  assign pcq_wr = '{pc: pc_q, inst: NOP_INST};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst_n     (reset),
    .flush_i   (1'b0),
    .push_i    (req_fire),
    .pop_i     (imem_rsp_valid),
    .wr_data_i (pcq_wr),
    .rd_data_o (pcq_head),
    .count_o   (out_cnt)
  );

  assign buf_wr = '{pc: pcq_head.pc, inst: imem_rsp_data};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst_n     (reset),
    .flush_i   (redirect_valid),
    .push_i    (rsp_keep),
    .pop_i     (inst_ready),
    .wr_data_i (buf_wr),
    .rd_data_o (buf_head),
    .count_o   (buf_cnt)
  );

  assign inst_valid  = (buf_cnt != '0);
  assign inst        = inst_valid ? buf_head.inst : '0;
  assign inst_pc     = inst_valid ? buf_head.pc   : '0;
  assign unused_bits = ^{pcq_head.inst, redirect_pc[1:0]};

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (inst_valid && inst_ready && !redirect_valid) fetched_q <= fetched_q + 32'd1;
      if (inst_ready && !inst_valid)                   stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level memory/decode model.
module tb_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk, reset;
  logic        imem_req_ready, imem_rsp_valid, redirect_valid, inst_ready;
  logic [31:0] imem_rsp_data, redirect_pc;
  logic        req_valid, inst_valid, req_valid2, inst_valid2;
  logic [31:0] req_addr, inst, inst_pc, req_addr2, inst2, inst_pc2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  // Same stimulus, different reset PC: handshake timing is address-independent,
  // so this instance tracks dut at a constant PC offset and exercises the wrap.
  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr2),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched2), .perf_stall(perf_stall2),
`endif
    .inst_valid(inst_valid2), .inst_ready(inst_ready), .inst(inst2), .inst_pc(inst_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];     // accepted by memory, response not yet returned
  logic [31:0] exp_q[$];    // PCs expected at the decode interface, in order
  logic [31:0] model_pc, off;
  int          epoch, cyc, pops, stalls, lat_max, checks, errors;
  bit          lat_rand;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rq_rdy, input bit i_rdy, input bit redir, input logic [31:0] rpc);
    bit   present, exp_valid, exp_req;
    int   lat;
    req_t r;
    @(negedge clk);
    imem_req_ready = rq_rdy;
    inst_ready     = i_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    present        = (pend.size() != 0) && (pend[0].due <= cyc);
    imem_rsp_valid = present;
    imem_rsp_data  = 32'h0;
    if (present) imem_rsp_data = mem_data(pend[0].addr);
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_req   = !redir && (pend.size() + exp_q.size() < DEPTH);
    check("inst_valid", inst_valid, exp_valid);
    check("w_inst_valid", inst_valid2, exp_valid);
    check("req_valid", req_valid, exp_req);
    check("w_req_valid", req_valid2, exp_req);
    if (exp_req) begin
      check("req_addr", req_addr, model_pc);
      check("w_req_addr", req_addr2, model_pc + off);
    end
    if (exp_valid) begin
      check("inst_pc", inst_pc, exp_q[0]);
      check("inst", inst, mem_data(exp_q[0]));
      check("w_inst_pc", inst_pc2, exp_q[0] + off);
      check("w_inst", inst2, mem_data(exp_q[0]));
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, pops);
    check("perf_stall", perf_stall, stalls);
    check("w_perf_fetched", perf_fetched2, pops);
`endif
    if (exp_valid && i_rdy && !redir) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (i_rdy && !exp_valid) stalls++;
    if (present) begin
      r = pend.pop_front();
      if (!redir && r.epoch == epoch) exp_q.push_back(r.addr);
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      model_pc = {rpc[31:2], 2'b00};
      off      = 32'h0;
    end else if (exp_req && rq_rdy) begin
      lat = lat_rand ? int'($urandom_range(lat_max, 1)) : lat_max;
      pend.push_back('{model_pc, epoch, cyc + lat});
      model_pc += 32'd4;
    end
    cyc++;
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_w_inst_pc", inst_pc2, 32'h0);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    pend.delete(); exp_q.delete();
    epoch++; model_pc = 32'h0; off = WRAP_PC; pops = 0; stalls = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; checks = 0; errors = 0; cyc = 0; epoch = 0;
    lat_max = 1; lat_rand = 1'b0;

    // Streaming, 1-cycle memory; dut_wrap walks FFFF_FFF8 -> FFFF_FFFC -> 0.
    apply_reset();
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    check("startup_valid", inst_valid, 1'b1);
    check("startup_pc", inst_pc, 32'h0);
    check("wrap_pc0", inst_pc2, 32'hFFFF_FFF8);
    step(1, 1, 0, 0);
    check("stream_pc1", inst_pc, 32'h4);
    check("wrap_pc1", inst_pc2, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check("wrap_pc2", inst_pc2, 32'h0000_0000);
    repeat (15) step(1, 1, 0, 0);

    // Backpressure: buffer fills, requests stop, then drain without gaps.
    repeat (10) step(1, 0, 0, 0);
    check("bp_req_valid", req_valid, 1'b0);
    check("bp_inst_valid", inst_valid, 1'b1);
    repeat (20) step(1, 1, 0, 0);

    // Redirect with outstanding requests on a 3-cycle memory.
    lat_max = 3;
    repeat (10) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0103);
    step(1, 1, 0, 0);
    check("redir_empty", inst_valid, 1'b0);
    repeat (15) step(1, 1, 0, 0);

    // Random traffic with back-to-back redirects and variable latency.
    lat_rand = 1'b1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
           $urandom_range(99, 0) < 3, $urandom());
    end

    // Async reset in the middle of a burst, then fetch restarts at RESET_PC.
    lat_rand = 1'b0; lat_max = 2;
    repeat (6) step(1, 1, 0, 0);
    apply_reset();
    repeat (20) step(1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
